// File: rtl/gpu_cmd_sequencer_if.sv
// rtl/gpu_cmd_sequencer_if.sv - engine handshake bundle between gpu_cmd_sequencer and its surroundings
interface gpu_cmd_sequencer_if #(
    parameter int CNT_W = 16
);
    logic             config_in;
    logic             config_done;
    logic             fifo_empty;
    logic             decode_fin;
    logic             inst_type;
    logic             bla_done;
    logic             fill_done;
    logic             alpha_done;
    logic             config_en;
    logic             read_en;
    logic             bla_en;
    logic             fill_en;
    logic             alpha_en;
    logic             busy;
    logic             frame_done;
    logic             err_timeout;
    logic [CNT_W-1:0] inst_count;

    modport master (
        output config_in, config_done, fifo_empty, decode_fin, inst_type,
               bla_done, fill_done, alpha_done,
        input  config_en, read_en, bla_en, fill_en, alpha_en,
               busy, frame_done, err_timeout, inst_count
    );

    modport slave (
        input  config_in, config_done, fifo_empty, decode_fin, inst_type,
               bla_done, fill_done, alpha_done,
        output config_en, read_en, bla_en, fill_en, alpha_en,
               busy, frame_done, err_timeout, inst_count
    );
endinterface

// File: rtl/gpu_cmd_sequencer.sv
// rtl/gpu_cmd_sequencer.sv - front/back FSM sequencer with decoded-instruction queue; SEQ_WATCHDOG_EN adds stall watchdog
module gpu_cmd_sequencer #(
    parameter int DEPTH       = 2,
    parameter int CNT_W       = 16,
    parameter int WDOG_CYCLES = 4095
) (
    input  logic                 clk,
    input  logic                 n_rst,
    gpu_cmd_sequencer_if.slave   bus
);
    typedef enum logic [2:0] {F_IDLE, F_CONFIG, F_CFG_WAIT, F_FETCH, F_HOLD} f_state_t;
    typedef enum logic [2:0] {B_IDLE, B_BLA, B_GAP, B_FILL, B_ALPHA, B_DONE} b_state_t;

    localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNTQ_W = $clog2(DEPTH + 1);

    f_state_t          f_state, f_next;
    b_state_t          b_state, b_next;
    logic [DEPTH-1:0]  q_mem;
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [CNTQ_W-1:0] q_count;
    logic [CNT_W-1:0]  inst_count;
    logic              q_full, push, pop, cfg_accept, inst_fin, abort;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign q_full     = (q_count == CNTQ_W'(DEPTH));
    assign push       = (f_state == F_FETCH) && bus.decode_fin && !q_full;
    assign pop        = (b_state == B_IDLE) && (q_count != '0);
    assign cfg_accept = (f_state == F_IDLE) && (b_state == B_IDLE) && bus.config_in;
    assign inst_fin   = ((b_state == B_FILL) && bus.fill_done) ||
                        ((b_state == B_ALPHA) && bus.alpha_done);

    always_comb begin
        f_next = f_state;
        case (f_state)
            F_IDLE:     if (cfg_accept) f_next = F_CONFIG;
            F_CONFIG:   if (bus.config_done) f_next = F_CFG_WAIT;
            F_CFG_WAIT: f_next = F_FETCH;
            F_FETCH:    if (push && bus.inst_type) f_next = F_HOLD;
            F_HOLD:     if (b_state == B_DONE) f_next = F_IDLE;
            default:    f_next = F_IDLE;
        endcase
        if (abort) f_next = F_IDLE;
    end

    always_comb begin
        b_next = b_state;
        case (b_state)
            B_IDLE:  if (pop) b_next = q_mem[rd_ptr] ? B_ALPHA : B_BLA;
            B_BLA:   if (bus.bla_done) b_next = B_GAP;
            B_GAP:   b_next = B_FILL;
            B_FILL:  if (bus.fill_done) b_next = B_IDLE;
            B_ALPHA: if (bus.alpha_done) b_next = B_DONE;
            B_DONE:  b_next = B_IDLE;
            default: b_next = B_IDLE;
        endcase
        if (abort) b_next = B_IDLE;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            f_state <= F_IDLE;
            b_state <= B_IDLE;
        end else begin
            f_state <= f_next;
            b_state <= b_next;
        end
    end

    // Circular queue; a watchdog abort flushes it in the same edge it idles the FSMs
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            q_mem   <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            q_count <= '0;
        end else if (abort) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            q_count <= '0;
        end else begin
            if (push) begin
                q_mem[wr_ptr] <= bus.inst_type;
                wr_ptr        <= ptr_inc(wr_ptr);
            end
            if (pop) rd_ptr <= ptr_inc(rd_ptr);
            case ({push, pop})
                2'b10:   q_count <= q_count + 1'b1;
                2'b01:   q_count <= q_count - 1'b1;
                default: q_count <= q_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            inst_count <= '0;
        end else if (cfg_accept) begin
            inst_count <= '0;
        end else if (inst_fin && !abort && (inst_count != '1)) begin
            inst_count <= inst_count + 1'b1;
        end
    end

`ifdef SEQ_WATCHDOG_EN
    localparam int WD_W = $clog2(WDOG_CYCLES + 1);

    logic [WD_W-1:0] wd_cnt;
    logic            err_q, wd_counting;

    assign wd_counting = (f_state == F_CONFIG) || (b_state == B_BLA) ||
                         (b_state == B_FILL) || (b_state == B_ALPHA);
    assign abort       = (wd_cnt == WD_W'(WDOG_CYCLES));

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wd_cnt <= '0;
            err_q  <= 1'b0;
        end else begin
            if ((f_next != f_state) || (b_next != b_state)) wd_cnt <= '0;
            else if (wd_counting) wd_cnt <= wd_cnt + 1'b1;
            if (abort) err_q <= 1'b1;
            else if (cfg_accept) err_q <= 1'b0;
        end
    end

    assign bus.err_timeout = err_q;
`else
    assign abort = 1'b0;
    // No watchdog: the limit can never be negative, so this is a constant 0
    assign bus.err_timeout = (WDOG_CYCLES < 0);
`endif

    assign bus.config_en  = (f_state == F_CONFIG);
    assign bus.read_en    = (f_state == F_FETCH) && !bus.fifo_empty && !q_full;
    assign bus.bla_en     = (b_state == B_BLA);
    assign bus.fill_en    = (b_state == B_FILL);
    assign bus.alpha_en   = (b_state == B_ALPHA);
    assign bus.frame_done = (b_state == B_DONE);
    assign bus.busy       = (f_state != F_IDLE) || (b_state != B_IDLE);
    assign bus.inst_count = inst_count;
endmodule

// File: tb/tb_gpu_cmd_sequencer.sv
// tb/tb_gpu_cmd_sequencer.sv - self-checking bench for gpu_cmd_sequencer (watchdog scenario under SEQ_WATCHDOG_EN)
module tb_gpu_cmd_sequencer;
    localparam int DEPTH = 2;
    localparam int CNT_W = 4;
    localparam int WDOG  = 16;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic clk = 1'b0;
    logic n_rst = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    gpu_cmd_sequencer_if #(.CNT_W(CNT_W)) bus ();

    gpu_cmd_sequencer #(.DEPTH(DEPTH), .CNT_W(CNT_W), .WDOG_CYCLES(WDOG)) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus.slave)
    );

    function automatic logic [7:0] outs();
        return {bus.config_en, bus.read_en, bus.bla_en, bus.fill_en,
                bus.alpha_en, bus.busy, bus.frame_done, bus.err_timeout};
    endfunction

    task automatic clear_inputs();
        bus.config_in   = 1'b0;
        bus.config_done = 1'b0;
        bus.fifo_empty  = 1'b0;
        bus.decode_fin  = 1'b0;
        bus.inst_type   = 1'b0;
        bus.bla_done    = 1'b0;
        bus.fill_done   = 1'b0;
        bus.alpha_done  = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        n_rst = 1'b0;
        repeat (2) @(posedge clk);
        #1 n_rst = 1'b1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Shared directed timeline: config@1, config_done@3, shape decoded @6 -> bla_en from cycle 8
    task automatic drive_directed(input int c, input bit with_done);
        bus.config_in   = (c == 1);
        bus.config_done = (c == 3);
        bus.fifo_empty  = 1'b0;
        bus.decode_fin  = (c == 6) || (with_done && c == 13);
        bus.inst_type   = with_done && (c == 13);
        bus.bla_done    = with_done && (c == 10);
        bus.fill_done   = with_done && (c == 14);
        bus.alpha_done  = with_done && (c == 20);
    endtask

    task automatic test_reset();
        do_reset();
        step();
        #1;
        checks++;
        if (outs() !== 8'h00) begin
            failures++;
            $display("FAIL reset_outs got=%b want=%b", outs(), 8'h00);
        end
        checks++;
        if (bus.inst_count !== '0) begin
            failures++;
            $display("FAIL reset_count got=%0d want=0", bus.inst_count);
        end
    endtask

    task automatic test_single_frame();
        logic [7:0]       exp;
        logic [CNT_W-1:0] exp_cnt;
        do_reset();
        for (int c = 0; c <= 24; c++) begin
            step();
            drive_directed(c, 1'b1);
            #1;
            exp = {(c >= 2 && c <= 3), (c >= 5 && c <= 13), (c >= 8 && c <= 10),
                   (c >= 12 && c <= 14), (c >= 16 && c <= 20), (c >= 2 && c <= 21),
                   (c == 21), 1'b0};
            exp_cnt = (c >= 21) ? CNT_W'(2) : (c >= 15) ? CNT_W'(1) : CNT_W'(0);
            checks++;
            if (outs() !== exp) begin
                failures++;
                $display("FAIL single_frame_outs c=%0d got=%b want=%b", c, outs(), exp);
            end
            checks++;
            if (bus.inst_count !== exp_cnt) begin
                failures++;
                $display("FAIL single_frame_count c=%0d got=%0d want=%0d", c, bus.inst_count, exp_cnt);
            end
        end
        clear_inputs();
    endtask

    task automatic test_reset_mid_bla();
        do_reset();
        for (int c = 0; c <= 9; c++) begin
            step();
            drive_directed(c, 1'b0);
        end
        #1;
        checks++;
        if (bus.bla_en !== 1'b1) begin
            failures++;
            $display("FAIL mid_bla_setup got=%b want=1", bus.bla_en);
        end
        n_rst = 1'b0;
        #1;
        checks++;
        if (outs() !== 8'h00 || bus.inst_count !== '0) begin
            failures++;
            $display("FAIL mid_bla_async got=%b/%0d want=%b/0", outs(), bus.inst_count, 8'h00);
        end
        clear_inputs();
        @(posedge clk);
        #1 n_rst = 1'b1;
        step();
        #1;
        checks++;
        if (outs() !== 8'h00 || bus.inst_count !== '0) begin
            failures++;
            $display("FAIL mid_bla_release got=%b/%0d want=%b/0", outs(), bus.inst_count, 8'h00);
        end
    endtask

`ifdef SEQ_WATCHDOG_EN
    task automatic test_watchdog();
        logic [7:0] exp;
        do_reset();
        for (int c = 0; c <= 30; c++) begin
            step();
            drive_directed(c, 1'b0);
            bus.config_in = (c == 1) || (c == 28);
            #1;
            exp = {((c >= 2 && c <= 3) || c >= 29), (c >= 5 && c <= 24),
                   (c >= 8 && c <= 24), 1'b0, 1'b0,
                   ((c >= 2 && c <= 24) || c >= 29), 1'b0, (c >= 25 && c <= 28)};
            checks++;
            if (outs() !== exp) begin
                failures++;
                $display("FAIL watchdog c=%0d got=%b want=%b", c, outs(), exp);
            end
        end
        do_reset();
    endtask
`endif

    // Randomised frames; reference keeps the queue as an SV queue and predicts timing from the handshake rules
    task automatic test_random_frames();
        logic             mq[$];
        logic [CNT_W-1:0] model_count;
        int  n_shapes, next_idx, cd, fd_at, busy0_at, fill_at, idle_at, stray_cfg_at;
        int  pushed_shapes, drawn_shapes, s_cfg, s_bla, s_fill, s_alpha;
        bit  alpha_pushed, finished, fetch, exp_read, exp_busy, planned, acc;
        logic cfg, bla, fill, alpha, p_bla, p_alpha;
        do_reset();
        model_count = '0;
        for (int f = 0; f < 8; f++) begin
            mq.delete();
            n_shapes = (f == 0) ? 18 : $urandom_range(0, 12);
            next_idx = 0; cd = -1; fd_at = -1; busy0_at = -1; fill_at = -1; idle_at = -1;
            stray_cfg_at = $urandom_range(3, 40);
            pushed_shapes = 0; drawn_shapes = 0;
            s_cfg = 0; s_bla = 0; s_fill = 0; s_alpha = 0;
            alpha_pushed = 0; finished = 0; p_bla = 0; p_alpha = 0;
            for (int c = 0; c < 3000 && !finished; c++) begin
                step();
                cfg = bus.config_en; bla = bus.bla_en; fill = bus.fill_en; alpha = bus.alpha_en;
                if ((bla && !p_bla) || (alpha && !p_alpha)) begin
                    checks++;
                    if (mq.size() == 0 || mq[0] !== alpha) begin
                        failures++;
                        $display("FAIL rand_order f=%0d c=%0d started=%s queued=%0d",
                                 f, c, alpha ? "alpha" : "bla", mq.size());
                    end
                    if (mq.size() != 0) void'(mq.pop_front());
                end
                s_cfg = cfg ? s_cfg + 1 : 0;       s_bla = bla ? s_bla + 1 : 0;
                s_fill = fill ? s_fill + 1 : 0;    s_alpha = alpha ? s_alpha + 1 : 0;
                bus.config_done = cfg   ? (s_cfg >= 5   || $urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
                bus.bla_done    = bla   ? (s_bla >= 5   || $urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
                bus.fill_done   = fill  ? (s_fill >= 5  || $urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
                bus.alpha_done  = alpha ? (s_alpha >= 5 || $urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
                bus.config_in   = (c == 1) || (c == stray_cfg_at && (busy0_at < 0 || c < busy0_at));
                bus.fifo_empty  = ($urandom_range(0, 3) == 0);
                bus.decode_fin  = 1'b0;
                bus.inst_type   = 1'b0;
                #1;
                fetch    = (cd >= 0) && (c >= cd + 2) && !alpha_pushed;
                exp_read = fetch && !bus.fifo_empty && (mq.size() < DEPTH);
                exp_busy = (c >= 2) && !(busy0_at >= 0 && c >= busy0_at);
                checks++;
                if (bus.read_en !== exp_read) begin
                    failures++;
                    $display("FAIL rand_read_en f=%0d c=%0d got=%b want=%b", f, c, bus.read_en, exp_read);
                end
                checks++;
                if ($countones({cfg, bla, fill, alpha}) > 1) begin
                    failures++;
                    $display("FAIL rand_onehot f=%0d c=%0d got=%b want=onehot0", f, c, {cfg, bla, fill, alpha});
                end
                checks++;
                if (bus.busy !== exp_busy || bus.frame_done !== (c == fd_at) || bus.err_timeout !== 1'b0) begin
                    failures++;
                    $display("FAIL rand_status f=%0d c=%0d got=%b%b%b want=%b%b0", f, c,
                             bus.busy, bus.frame_done, bus.err_timeout, exp_busy, (c == fd_at));
                end
                checks++;
                if (bus.inst_count !== model_count) begin
                    failures++;
                    $display("FAIL rand_count f=%0d c=%0d got=%0d want=%0d", f, c, bus.inst_count, model_count);
                end
                if (c == fill_at - 1 || c == fill_at || c == idle_at) begin
                    checks++;
                    if ({bla, fill, alpha} !== {1'b0, (c == fill_at), 1'b0}) begin
                        failures++;
                        $display("FAIL rand_latency f=%0d c=%0d got=%b want=%b", f, c,
                                 {bla, fill, alpha}, {1'b0, (c == fill_at), 1'b0});
                    end
                end
                planned = bus.read_en && ($urandom_range(0, 1) == 0);
                if (planned || (!bus.read_en && $urandom_range(0, 7) == 0)) begin
                    bus.decode_fin = 1'b1;
                    bus.inst_type  = planned && (next_idx >= n_shapes);
                end
                acc = bus.decode_fin && fetch && (mq.size() < DEPTH);
                if (acc) begin
                    mq.push_back(bus.inst_type);
                    if (bus.inst_type) alpha_pushed = 1;
                    else pushed_shapes++;
                    if (planned) next_idx++;
                end
                if (c == 1) model_count = '0;
                if (cfg && bus.config_done) cd = c;
                if (bla && bus.bla_done) fill_at = c + 2;
                if ((fill && bus.fill_done) || (alpha && bus.alpha_done))
                    model_count = (model_count == CNT_MAX) ? CNT_MAX : model_count + 1'b1;
                if (fill && bus.fill_done) begin
                    idle_at = c + 1;
                    drawn_shapes++;
                end
                if (alpha && bus.alpha_done) begin
                    fd_at = c + 1;
                    busy0_at = c + 2;
                end
                if (c == busy0_at) finished = 1;
                p_bla = bla; p_alpha = alpha;
            end
            checks++;
            if (!finished || mq.size() != 0 || drawn_shapes != pushed_shapes) begin
                failures++;
                $display("FAIL rand_frame_end f=%0d finished=%0b queued=%0d drawn=%0d want_drawn=%0d",
                         f, finished, mq.size(), drawn_shapes, pushed_shapes);
            end
            clear_inputs();
        end
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_single_frame();
        test_reset_mid_bla();
`ifdef SEQ_WATCHDOG_EN
        test_watchdog();
`endif
        test_random_frames();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/gpu_cmd_sequencer.md
# gpu_cmd_sequencer

Parametrised successor to the GPU main controller. Sequences configuration, instruction decode, line rasterisation (BLA), fill and alpha blend. A DEPTH-entry decoded-instruction queue lets the decoder run ahead of the draw engines, so decode overlaps draw. An optional watchdog aborts any stage that stalls. Sits between the instruction FIFO/decoder and the BLA, fill, alpha and config engines.

## Interface
- DEPTH, 2: decoded-instruction queue entries, legal 1..8
- CNT_W, 16: width of inst_count
- WDOG_CYCLES, 4095: stall limit in cycles for any engine-wait state (watchdog builds only)
- clk  in  1  clock
- n_rst  in  1  reset n_rst, asynchronous, active-low; clock clk
- config_in  in  1  start-of-frame configuration request
- config_done  in  1  config engine finished
- fifo_empty  in  1  instruction FIFO empty
- decode_fin  in  1  decoder produced one instruction this cycle
- inst_type  in  1  type of that instruction, valid with decode_fin: 0 = shape, 1 = alpha (frame terminator)
- bla_done, fill_done, alpha_done  in  1 each  engine completion pulses
- config_en, read_en, bla_en, fill_en, alpha_en  out  1 each  engine enables
- busy  out  1  either FSM not idle
- frame_done  out  1  one-cycle pulse at end of frame
- err_timeout  out  1  sticky watchdog error
- inst_count  out  CNT_W  completed instructions this frame, saturating

## Operation
- Front FSM: F_IDLE, F_CONFIG, F_CFG_WAIT, F_FETCH, F_HOLD.
  - F_IDLE -> F_CONFIG on config_in. config_in is ignored while busy.
  - F_CONFIG drives config_en=1. Leaves for F_CFG_WAIT on config_done.
  - F_CFG_WAIT lasts one cycle, then F_FETCH.
  - F_FETCH: read_en = !fifo_empty && queue_count<DEPTH.
  - In F_FETCH, decode_fin pushes inst_type into the queue. A push with inst_type=1 moves the FSM to F_HOLD; fetching stops at the alpha barrier.
  - F_HOLD -> F_IDLE when the back FSM reaches B_DONE.
- Back FSM: B_IDLE, B_BLA, B_GAP, B_FILL, B_ALPHA, B_DONE.
  - B_IDLE with a non-empty queue pops the head entry: type 0 -> B_BLA, type 1 -> B_ALPHA.
  - B_BLA drives bla_en. Leaves for B_GAP on bla_done.
  - B_GAP lasts one cycle, then B_FILL.
  - B_FILL drives fill_en. On fill_done: inst_count++ and go to B_IDLE.
  - B_ALPHA drives alpha_en. On alpha_done: inst_count++ and go to B_DONE.
  - B_DONE lasts one cycle: frame_done=1, then B_IDLE.
- Queue: circular buffer with wrapping pointers and a count.
  - Push and pop in the same cycle leaves the count unchanged.
  - decode_fin outside F_FETCH, or with the queue full, is ignored (dropped).
- Done inputs outside their owning state are ignored.
- inst_count clears on entry to F_CONFIG and saturates at all-ones.
- All enables are one-hot or zero: at most one of config_en/bla_en/fill_en/alpha_en is high. read_en may be high together with bla_en, fill_en or alpha_en.
- Reset mid-operation: both FSMs go to idle immediately, the queue empties and all outputs drop to reset values.

## Timing
- Reset values: every output 0, inst_count 0, queue empty, FSMs F_IDLE/B_IDLE.
- Enables decode from registered state. read_en also depends combinationally on fifo_empty.
- config_in in cycle k -> config_en in cycle k+1.
- config_done in cycle k -> F_CFG_WAIT in k+1 -> read_en possible in k+2.
- decode_fin in cycle k (back idle) -> queue non-empty in k+1 -> bla_en in k+2.
- bla_done in cycle k -> fill_en in k+2.
- fill_done in cycle k -> B_IDLE in k+1 -> next bla_en in k+2 if the queue is non-empty.
- alpha_done in cycle k -> frame_done in k+1 -> busy=0 in k+2.

## Configuration
- SEQ_WATCHDOG_EN defined: one cycle counter, reset on every state change. It counts while in F_CONFIG, B_BLA, B_FILL or B_ALPHA.
  - On reaching WDOG_CYCLES, in the next cycle err_timeout=1, both FSMs go idle, the queue is flushed and all enables are 0.
  - err_timeout clears on the next accepted config_in.
- Undefined: no counter, err_timeout tied to 0, and WDOG_CYCLES is unused.

## Test plan
- Reset mid-BLA: n_rst low while bla_en=1 -> all outputs 0 asynchronously; inst_count=0 and busy=0 after release.
- Single frame, one shape plus alpha, DEPTH=2: config_in@1, config_done@3, decode_fin type0@6, bla_done@10, fill_done@14, decode_fin type1 during fill, alpha_done@20 -> bla_en 8-10, fill_en 12-14, alpha_en 16-20, frame_done@21, inst_count=2.
- Overlap/full: DEPTH=2, three shapes decoded back-to-back while BLA stalls -> read_en drops once count=2; a stray decode_fin while full is dropped; all three shapes are drawn in order once released.
- Wrap-around: DEPTH=3, ten shapes plus alpha -> ten bla/fill pairs in push order, inst_count=11.
- Simultaneous push/pop: decode_fin in the same cycle B_IDLE pops -> count unchanged, no entry lost.
- Watchdog (SEQ_WATCHDOG_EN, WDOG_CYCLES=16): bla_done never asserts -> err_timeout=1 17 cycles after bla_en rises, bla_en=0, busy=0; the next config_in clears err_timeout.
